// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 16;

  // Divide-by-zero quotient is all ones; callers slice to their own width.
  localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_rq_reg.sv
// Combined remainder/quotient {A,Q} register: load, then one shift-subtract step per clock.
module div_rq_reg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_q_nxt,
  output logic [WIDTH-1:0] o_rem_nxt
);

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  // Trial subtract on the full shifted A (one extra bit) so the borrow is never lost.
  assign w_trial = {r_a, r_q[WIDTH-1]} - {2'b00, r_d};

  always_comb begin
    w_a_nxt = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
    if (!w_trial[WIDTH+1]) begin
      w_a_nxt = w_trial[WIDTH:0];
      w_q_nxt = {r_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a <= '0;
      r_q <= '0;
      r_d <= '0;
    end else if (i_load) begin
      r_a <= '0;
      r_q <= i_dividend;
      r_d <= i_divisor;
    end else if (i_step) begin
      r_a <= w_a_nxt;
      r_q <= w_q_nxt;
    end
  end

  assign o_q_nxt   = w_q_nxt;
  assign o_rem_nxt = w_a_nxt[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: FSM, iteration counter and result registers around div_rq_reg.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic             w_accept;
  logic             w_div0;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rem_nxt;

  // FIN accepts like IDLE so back-to-back operations lose no cycle.
  assign w_accept = i_start && (r_state == IDLE || r_state == FIN);
  assign w_div0   = (i_divisor == '0);
  assign w_load   = w_accept && !w_div0;
  assign w_step   = (r_state == CALC);

  div_rq_reg #(.WIDTH(WIDTH)) u_rq (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_q_nxt    (w_q_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_quot  <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_state <= FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (w_accept) begin
            if (w_div0) begin
              r_quot  <= DIV0_QUOT[WIDTH-1:0];
              r_rem   <= i_dividend;
              r_dz    <= 1'b1;
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= CNT_W'(WIDTH);
              r_dz    <= 1'b0;
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign o_quotient  = r_quot;
  assign o_remainder = r_rem;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_div_zero  = r_dz;

endmodule

// File: tb/tb_div_seq.sv
// Directed and swept checks of div_seq: results, latency, Busy/Done timing, reset, back-to-back.
module tb_div_seq;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [W-1:0] i_dividend;
  logic [W-1:0] i_divisor;
  logic [W-1:0] o_quotient;
  logic [W-1:0] o_remainder;
  logic         o_busy;
  logic         o_done;
  logic         o_div_zero;

  int n_chk  = 0;
  int n_fail = 0;

  div_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_dividend  (i_dividend),
    .i_divisor   (i_divisor),
    .o_quotient  (o_quotient),
    .o_remainder (o_remainder),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_div_zero  (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for Done at negedges, counting cycles and Busy cycles before it.
  task automatic wait_done(output int lat, output int bsy, output bit ok);
    lat = 0; bsy = 0; ok = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_done) break;
      if (o_busy) bsy++;
      lat++;
      if (lat > 40) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int lat, bsy;
    bit ok;
    @(negedge i_clk);
    i_start = 1'b1; i_dividend = a; i_divisor = b;
    @(posedge i_clk);
    #1;
    i_start = 1'b0; i_dividend = ~a; i_divisor = b + 16'd3;
    wait_done(lat, bsy, ok);
    chk("done_seen", 32'(ok), 32'd1);
    chk("latency", 32'(lat), edz ? 32'd0 : 32'd16);
    chk("busy_cycles", 32'(bsy), edz ? 32'd0 : 32'd16);
    chk("quotient", 32'(o_quotient), 32'(eq));
    chk("remainder", 32'(o_remainder), 32'(er));
    chk("div_zero", 32'(o_div_zero), 32'(edz));
    if (b != 0) chk("invariant", 32'(o_quotient) * 32'(b) + 32'(o_remainder), 32'(a));
    @(negedge i_clk);
    chk("done_pulse_1cyc", 32'(o_done), 32'd0);
  endtask

  initial begin
    int lat, bsy;
    bit ok;
    logic [W-1:0] ra, rb;

    vecs[0] = '{16'd100,   16'd7,      16'd14,   16'd2,    1'b0};
    vecs[1] = '{16'hFFFF,  16'd1,      16'hFFFF, 16'd0,    1'b0};
    vecs[2] = '{16'd3,     16'd10,     16'd0,    16'd3,    1'b0};
    vecs[3] = '{16'd5,     16'd0,      16'hFFFF, 16'd5,    1'b1};
    vecs[4] = '{16'h8000,  16'h8001,   16'd0,    16'h8000, 1'b0};
    vecs[5] = '{16'hFFFF,  16'hFFFF,   16'd1,    16'd0,    1'b0};
    vecs[6] = '{16'd0,     16'd5,      16'd0,    16'd0,    1'b0};
    vecs[7] = '{16'd1000,  16'd10,     16'd100,  16'd0,    1'b0};
    vecs[8] = '{16'hFFFF,  16'h0100,   16'h00FF, 16'h00FF, 1'b0};
    vecs[9] = '{16'd12345, 16'd123,    16'd100,  16'd45,   1'b0};

    i_rst_n = 1'b0; i_start = 1'b0; i_dividend = '0; i_divisor = '0;
    #12;
    chk("rst_quot", 32'(o_quotient), 32'd0);
    chk("rst_rem", 32'(o_remainder), 32'd0);
    chk("rst_flags", {29'd0, o_busy, o_done, o_div_zero}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // Start held through CALC with new operands is ignored, then accepted in FIN.
    @(negedge i_clk);
    i_start = 1'b1; i_dividend = 16'd100; i_divisor = 16'd7;
    @(posedge i_clk);
    #1;
    i_dividend = 16'd9; i_divisor = 16'd2;
    wait_done(lat, bsy, ok);
    chk("b2b_first_done", 32'(ok), 32'd1);
    chk("b2b_first_lat", 32'(lat), 32'd16);
    chk("b2b_first_q", 32'(o_quotient), 32'd14);
    chk("b2b_first_r", 32'(o_remainder), 32'd2);
    @(negedge i_clk);
    i_start = 1'b0;
    chk("b2b_no_gap_busy", 32'(o_busy), 32'd1);
    wait_done(lat, bsy, ok);
    chk("b2b_second_done", 32'(ok), 32'd1);
    chk("b2b_second_lat", 32'(lat), 32'd15);
    chk("b2b_second_q", 32'(o_quotient), 32'd4);
    chk("b2b_second_r", 32'(o_remainder), 32'd1);
    @(negedge i_clk);

    // Asynchronous reset in the middle of CALC abandons the operation.
    i_start = 1'b1; i_dividend = 16'd100; i_divisor = 16'd7;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    repeat (8) @(negedge i_clk);
    chk("mid_busy", 32'(o_busy), 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_quot", 32'(o_quotient), 32'd0);
    chk("arst_rem", 32'(o_remainder), 32'd0);
    chk("arst_flags", {29'd0, o_busy, o_done, o_div_zero}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (20) begin
        @(negedge i_clk);
        if (o_done || o_busy) seen++;
      end
      chk("arst_no_done", 32'(seen), 32'd0);
    end
    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    // Sweep with a reference division as the model.
    for (int k = 0; k < 1000; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 4 == 0) rb = 16'($urandom_range(1, 255));
      if (k == 0) begin ra = 16'h8000; rb = 16'h8001; end
      if (k == 1) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      if (k == 2) rb = 16'd0;
      if (rb == 0) run_op(ra, rb, 16'hFFFF, ra, 1'b1);
      else         run_op(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
